// File: rtl/insn_mem_pkg.sv
// Shared definitions for the instruction memory controller: load FSM
// encoding, address/beat width helpers and the geometry check.
package insn_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A program must fill the memory with a whole number of beats.
  function automatic bit beats_fit(input int insn_count, input int bus_count);
    return (bus_count > 0) && ((insn_count % bus_count) == 0);
  endfunction

endpackage

// File: rtl/insn_mem_load_fsm.sv
// Burst loader sequencer: tracks the next beat of a program load and
// raises a write strobe for every accepted beat.
module insn_mem_load_fsm
  import insn_mem_pkg::*;
#(
  parameter int LOAD_BEATS = 32,
  parameter int BW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  output logic          load_busy,
  output logic          load_done,
  output logic [BW-1:0] load_beat,
  output logic          wr_en
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(LOAD_BEATS - 1);

  load_state_e state;

  // A beat arriving together with a restart request is dropped.
  assign wr_en = (state == LOAD) && load_valid && !load_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_ready <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            load_busy  <= 1'b1;
            load_done  <= 1'b0;
            load_beat  <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            load_beat <= '0;
          end else if (load_valid) begin
            if (load_beat == LAST_BEAT) begin
              state      <= IDLE;
              load_ready <= 1'b0;
              load_busy  <= 1'b0;
              load_done  <= 1'b1;
              load_beat  <= '0;
            end else begin
              load_beat <= load_beat + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
          load_beat  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/insn_mem_ctrl.sv
// Instruction memory with a self-sequencing burst loader and several
// independent one-cycle-latency read ports.
module insn_mem_ctrl
  import insn_mem_pkg::*;
#(
  parameter int INSN_SIZE  = 16,
  parameter int INSN_COUNT = 256,
  parameter int BUS_COUNT  = 8,
  parameter int READ_PORTS = 2,
  localparam int LOAD_BEATS = INSN_COUNT / BUS_COUNT,
  localparam int AW         = width_of(INSN_COUNT),
  localparam int BW         = width_of(LOAD_BEATS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic                            load_valid,
  input  logic [BUS_COUNT*INSN_SIZE-1:0]  load_data,
  output logic                            load_ready,
  output logic                            load_busy,
  output logic                            load_done,
  output logic [BW-1:0]                   load_beat,
  input  logic [READ_PORTS-1:0]           rd_en,
  input  logic [READ_PORTS*AW-1:0]        rd_addr,
  output logic [READ_PORTS*INSN_SIZE-1:0] rd_data,
  output logic [READ_PORTS-1:0]           rd_err
);

  if (!beats_fit(INSN_COUNT, BUS_COUNT)) begin : g_bad_geometry
    $error("insn_mem_ctrl: INSN_COUNT must be a multiple of BUS_COUNT");
  end

  logic wr_en;

  insn_mem_load_fsm #(
    .LOAD_BEATS (LOAD_BEATS),
    .BW         (BW)
  ) u_load_fsm (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_beat  (load_beat),
    .wr_en      (wr_en)
  );

  // Array contents are deliberately left out of reset.
  logic [INSN_SIZE-1:0] mem [INSN_COUNT];

  function automatic logic [AW-1:0] slot_addr(input logic [BW-1:0] beat, input int slot);
    return AW'(int'(beat) * BUS_COUNT + slot);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < BUS_COUNT; j++) begin
        mem[slot_addr(load_beat, j)] <= load_data[j*INSN_SIZE +: INSN_SIZE];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]        addr;
    logic                 in_range;
    logic [INSN_SIZE-1:0] data_q;
    logic                 err_q;

    assign addr     = rd_addr[p*AW +: AW];
    assign in_range = int'(addr) < INSN_COUNT;

    // Registered read samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q <= '0;
        err_q  <= 1'b0;
      end else if (rd_en[p]) begin
        data_q <= in_range ? mem[addr] : '0;
        err_q  <= !in_range;
      end
    end

    assign rd_data[p*INSN_SIZE +: INSN_SIZE] = data_q;
    assign rd_err[p]                         = err_q;
  end

endmodule

// File: doc/insn_mem_ctrl.md
# insn_mem_ctrl

Parametrised instruction memory with a self-sequencing burst loader and multiple registered read ports. It sits between the host/instruction-bus interface and the core fetch stages. It accepts a program as a stream of wide bus beats over a valid/ready handshake, counts beats internally, and signals completion. Several fetch units can read it independently, each with one-cycle latency.

## Interface
Parameters:
- INSN_SIZE, 16: bits per instruction.
- INSN_COUNT, 256: memory depth in instructions; must be a multiple of BUS_COUNT.
- BUS_COUNT, 8: instructions carried per load beat.
- READ_PORTS, 2: number of independent read ports.
- Derived: LOAD_BEATS = INSN_COUNT/BUS_COUNT; AW = max(1, clog2(INSN_COUNT)); BW = max(1, clog2(LOAD_BEATS)).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low.
- load_start  in  1  one-cycle request to begin (or restart) a program load.
- load_valid  in  1  beat on load_data is valid.
- load_data  in  BUS_COUNT*INSN_SIZE  beat; instruction j in bits [(j+1)*INSN_SIZE-1 : j*INSN_SIZE].
- load_ready  out  1  beat accepted this cycle when load_valid & load_ready.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  sticky: full program loaded; cleared by load_start or reset.
- load_beat  out  BW  index of the next beat expected.
- rd_en  in  READ_PORTS  per-port read strobe.
- rd_addr  in  READ_PORTS*AW  per-port instruction address; port p in [(p+1)*AW-1 : p*AW].
- rd_data  out  READ_PORTS*INSN_SIZE  per-port registered read data.
- rd_err  out  READ_PORTS  registered; rd_addr >= INSN_COUNT on the last enabled read.

## Operation
- FSM states: IDLE, LOAD.
- IDLE: load_ready=0, load_busy=0. On load_start: go to LOAD, set beat counter to 0, clear load_done.
- LOAD: load_ready=1, load_busy=1. On a handshake, write instruction j of the beat to address load_beat*BUS_COUNT + j for all j, then increment load_beat.
  - On a handshake at beat LOAD_BEATS-1: go to IDLE, set load_done=1, reset load_beat to 0.
- load_start in LOAD aborts the load and restarts it: load_beat goes to 0 and load_done stays 0. A beat presented in the same cycle as that load_start is discarded.
- load_valid in IDLE is ignored; memory is unchanged.
- Memory array contents are not reset. Only the FSM, counter, flags and read registers are reset.
- Read port p, when rd_en[p]=1:
  - rd_data[p] takes mem[rd_addr[p]] at the next edge, or 0 if the address is out of range.
  - rd_err[p] takes the range check result at the same edge.
- When rd_en[p]=0, rd_data[p] and rd_err[p] hold their values.
- Reads are allowed in any state; reads are not gated by load_done.
- Read and write to the same address in the same cycle: read returns the old contents (read-before-write).
- Multiple ports reading the same address all receive the same data.

## Timing
- Reset values: state IDLE, load_ready 0, load_busy 0, load_done 0, load_beat 0, rd_data all 0, rd_err all 0.
- Reset asserted mid-load: the FSM returns to IDLE immediately and asynchronously. Beats already written stay in memory, and load_done stays 0.
- load_start at edge N: load_ready=1 from cycle N+1.
- A full load at load_valid=1 every cycle takes LOAD_BEATS cycles of handshake. load_done=1 in the cycle after the last beat.
- Read latency is 1 cycle: address at edge N produces data valid after edge N, usable in cycle N+1.
- Written data is readable by a read issued on the cycle after the write edge.
- load_ready depends only on the state; it has no combinational path from load_valid.

## Structure
- Shared package insn_mem_pkg holds:
  - the FSM state encoding (IDLE=0, LOAD=1);
  - the clog2-based width helper functions used for AW and BW;
  - the elaboration check that INSN_COUNT % BUS_COUNT == 0.
- Sub-module insn_mem_load_fsm contains the state register, beat counter, and load_ready/load_busy/load_done logic. It outputs a write-enable and the beat index.
- The top level holds the memory array, the write fan-out of BUS_COUNT instructions, and the generate loop over READ_PORTS read registers.

## Test plan
- Reset, then full load with defaults: 32 beats where instruction k = 16'hA000+k. Required: load_done=1 one cycle after beat 31; every read port at addresses 0, 7, 255 returns 16'hA000, 16'hA007, 16'hA0FF.
- Valid stalls: load_valid toggles 1/0 during a load. Required: load_beat advances only on handshakes; final contents are identical to the uninterrupted load.
- Restart: load_start at beat 10, then a full load with instruction k = 16'h5000+k. Required: all 256 addresses read 16'h5xxx; the beat presented with load_start is not written.
- Reset mid-load at beat 5: required outputs are 0 and state is IDLE. Addresses 0..39 keep the new data; load_ready=0 until the next load_start.
- Read-during-write: port 0 reads address 16 in the same cycle beat 2 writes it. Required: old value returned; the next-cycle read returns the new value. Port 1 with rd_en=0 holds its previous data.
- Out-of-range read with INSN_COUNT=24, BUS_COUNT=8: a read of address 30 returns rd_data=0 and rd_err=1. The next valid read clears rd_err.
